// File: rtl/tile_cfg_loader.sv
// -----------------------------------------------------------------------------
// tile_cfg_loader
//
// Streams a configuration bitstream in as WORD_W-bit words and writes one
// CFG_BITS-wide frame into each of NUM_TILES tiles, in tile order 0..N-1.
// The first word of every frame carries the frame MSBs; the surplus
// (WPF*WORD_W - CFG_BITS) MSBs of that first word fall off the top of the
// shift register and are discarded.
//
// Optional feature (macro CFG_CHECK_EN): each frame is followed by one extra
// check word that must equal the XOR of the frame's WPF data words. A
// mismatch sets the sticky err flag and ends the sequence without writing
// that tile or any later one.
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      asynchronous, active-high reset
//   start      begin a load sequence; only sampled in IDLE
//   din        config word (first word of a frame holds the frame MSBs)
//   din_valid  din holds a valid word
//   din_ready  loader accepts din this cycle (decoded from state)
//   wr_en      one-hot per-tile write strobe, one cycle wide
//   bits       frame being written; valid whenever wr_en is non-zero, and
//              holds the last committed frame between pulses
//   busy       high from the cycle after start is accepted until DONE exits
//   done       one-cycle pulse at end of sequence
//   err        sticky check failure, cleared by the next accepted start
//   state_dbg  current FSM state encoding (IDLE=0 LOAD=1 CHECK=2 COMMIT=3
//              DONE=4)
//
// Handshake: a word transfers on a posedge where din_valid and din_ready are
// both high. din_valid may drop at any time; din may change freely while the
// word is not being accepted. din_ready never depends on din_valid.
// -----------------------------------------------------------------------------
module tile_cfg_loader #(
  parameter int NUM_TILES = 4,
  parameter int CFG_BITS  = 77,
  parameter int WORD_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WORD_W-1:0]    din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [NUM_TILES-1:0] wr_en,
  output logic [CFG_BITS-1:0]  bits,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           state_dbg
);

  localparam int WPF = (CFG_BITS + WORD_W - 1) / WORD_W;
  localparam int WCW = $clog2(WPF + 1);
  localparam int TW  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CHECK  = 3'd2,
    S_COMMIT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CFG_BITS-1:0] frame_sr;
  logic [WCW-1:0]      word_cnt;
  logic [TW-1:0]       tile_idx;
  logic                last_word;
  logic                last_tile;
  logic                load_xfer;

  assign last_word = (word_cnt == WCW'(WPF - 1));
  assign last_tile = (tile_idx == TW'(NUM_TILES - 1));
  assign load_xfer = (state_q == S_LOAD) && din_valid;
  assign state_dbg = state_q;

`ifdef CFG_CHECK_EN
  logic [WORD_W-1:0] xor_q;
  logic              err_q;
  logic              check_ok;

  assign check_ok = (din == xor_q);
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next state and din_ready decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    din_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        din_ready = 1'b1;
        if (din_valid && last_word) begin
`ifdef CFG_CHECK_EN
          state_d = S_CHECK;
`else
          state_d = S_COMMIT;
`endif
        end
      end
`ifdef CFG_CHECK_EN
      S_CHECK: begin
        din_ready = 1'b1;
        if (din_valid) state_d = check_ok ? S_COMMIT : S_DONE;
      end
`endif
      S_COMMIT: begin
        state_d = last_tile ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: frame assembly, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_sr <= '0;
      word_cnt <= '0;
      tile_idx <= '0;
      wr_en    <= '0;
      bits     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Strobes default low so each pulse lasts exactly one cycle.
      wr_en <= '0;
      done  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            word_cnt <= '0;
            tile_idx <= '0;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_xfer) begin
            // Shift left by one word; the truncating cast drops the bits that
            // move past CFG_BITS, which is where the first word's surplus
            // MSBs end up after WPF words.
            frame_sr <= CFG_BITS'({frame_sr, din});
            word_cnt <= word_cnt + WCW'(1);
          end
        end
        S_COMMIT: begin
          bits     <= frame_sr;
          wr_en    <= NUM_TILES'(1) << tile_idx;
          word_cnt <= '0;
          if (!last_tile) tile_idx <= tile_idx + TW'(1);
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CFG_CHECK_EN
  // Running XOR of the current frame's data words, and the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xor_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            xor_q <= '0;
            err_q <= 1'b0;
          end
        end
        S_LOAD: begin
          if (din_valid) xor_q <= xor_q ^ din;
        end
        S_CHECK: begin
          if (din_valid) begin
            xor_q <= '0;
            if (!check_ok) err_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_tile_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_tile_cfg_loader
//
// Directed bench for tile_cfg_loader. Instance u_dut uses the default
// parameters (4 tiles, 77-bit frames, 8-bit words); instance u_dut1 uses
// NUM_TILES=1, CFG_BITS=16, WORD_W=8. Frames are given as 80-bit word
// streams (first word in the top byte) next to their hand-derived 77-bit
// results. Expected writes are queued when a frame is issued and popped by
// monitors whenever a wr_en pulse appears.
// -----------------------------------------------------------------------------
module tb_tile_cfg_loader;

  localparam int NT = 4;
  localparam int CB = 77;
  localparam int WW = 8;
  localparam int EW = NT + CB;

  // Default-parameter DUT
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start;
  logic [WW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [NT-1:0] wr_en;
  logic [CB-1:0] bits;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    state_dbg;

  // Single-tile DUT
  logic          start1;
  logic [7:0]    din1;
  logic          din_valid1;
  logic          din_ready1;
  logic [0:0]    wr_en1;
  logic [15:0]   bits1;
  logic          busy1;
  logic          done1;
  logic          err1;
  logic [2:0]    state_dbg1;

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  logic [16:0]   exp1_q[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            lat_exp = 0;
  bit            lat_on = 1'b0;
  logic          err_exp = 1'b0;
  int            done_cnt = 0;
  logic          prev_done = 1'b0;
  logic [NT-1:0] prev_wr = '0;

  // Frames: 80-bit word streams and their expected 77-bit results
  localparam logic [79:0] A0 = 80'hF38447C08010129071FF;
  localparam logic [CB-1:0] A0_E =
    77'b10011100001000100011111_000000100000000001_000000010010100100_000111000111111111;
  localparam logic [79:0]   A1   = 80'h0102030405060708090A;
  localparam logic [CB-1:0] A1_E = 77'h102030405060708090A;
  localparam logic [79:0]   A2   = 80'hE4000000000000000000;
  localparam logic [CB-1:0] A2_E = 77'h4000000000000000000;
  localparam logic [79:0]   A3   = 80'hFFFFFFFFFFFFFFFFFFFF;
  localparam logic [CB-1:0] A3_E = {CB{1'b1}};
  localparam logic [79:0]   B0   = 80'hAAAAAAAAAAAAAAAAAAAA;
  localparam logic [CB-1:0] B0_E = 77'hAAAAAAAAAAAAAAAAAAA;
  localparam logic [79:0]   B1   = 80'h55555555555555555555;
  localparam logic [CB-1:0] B1_E = 77'h15555555555555555555;
  localparam logic [79:0]   B2   = 80'h00000000000000000001;
  localparam logic [CB-1:0] B2_E = 77'h1;
  localparam logic [79:0]   B3   = 80'h0F0F0F0F0F0F0F0F0F0F;
  localparam logic [CB-1:0] B3_E = 77'hF0F0F0F0F0F0F0F0F0F;
  localparam logic [79:0]   C0   = 80'h13000000000000000000;
  localparam logic [CB-1:0] C0_E = 77'h13000000000000000000;

  tile_cfg_loader u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .wr_en     (wr_en),
    .bits      (bits),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg)
  );

  tile_cfg_loader #(.NUM_TILES(1), .CFG_BITS(16), .WORD_W(8)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .start     (start1),
    .din       (din1),
    .din_valid (din_valid1),
    .din_ready (din_ready1),
    .wr_en     (wr_en1),
    .bits      (bits1),
    .busy      (busy1),
    .done      (done1),
    .err       (err1),
    .state_dbg (state_dbg1)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Helpers and driver tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word transferred.
  task automatic send_word(input logic [7:0] w, input int gap);
    int guard = 0;
    din       = w;
    din_valid = 1'b1;
    while (!din_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("din_ready_wait", din_ready, 1'b1);
    @(negedge clk);
    din_valid = 1'b0;
    din       = 8'($urandom_range(0, 255));
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [79:0] w, input logic [CB-1:0] eb, input int tile,
                            input int gap, input int start_at, input bit bad);
    logic [NT-1:0] we;
    logic [7:0]    wb;
`ifdef CFG_CHECK_EN
    logic [7:0]    x;
    x = 8'h00;
`endif
    we       = '0;
    we[tile] = 1'b1;
    if (!bad) exp_q.push_back({we, eb});
    for (int i = 0; i < 10; i++) begin
      wb = w[79-8*i -: 8];
`ifdef CFG_CHECK_EN
      x = x ^ wb;
`endif
      if (i == start_at) start = 1'b1;
      send_word(wb, gap);
      start = 1'b0;
    end
`ifdef CFG_CHECK_EN
    send_word(bad ? (x ^ 8'h01) : x, gap);
`endif
  endtask

  task automatic do_start();
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("ready_after_start", din_ready, 1'b1);
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", done, 1'b1);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset) begin
      if (wr_en != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_en_unexpected: got wr_en=%b with nothing expected", wr_en);
        end else begin
          e = exp_q.pop_front();
          chk("wr_en", wr_en, e[EW-1:CB]);
          chk("bits", bits, e[CB-1:0]);
          chk("wr_en_one_cycle", prev_wr, '0);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_busy_low", busy, 1'b0);
        chk("done_one_cycle", prev_done, 1'b0);
        chk("done_err", err, err_exp);
        if (lat_on) chk("load_latency", cyc - start_cyc, lat_exp);
      end
    end
    prev_wr   = wr_en;
    prev_done = done;
  end

  always @(negedge clk) begin
    logic [16:0] e1;
    if (!reset && wr_en1 != 1'b0) begin
      if (exp1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_en1_unexpected: got wr_en1=%b with nothing expected", wr_en1);
      end else begin
        e1 = exp1_q.pop_front();
        chk("wr_en1", wr_en1, e1[16]);
        chk("bits1", bits1, e1[15:0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int g;
    start = 1'b0; din = '0; din_valid = 1'b0;
    start1 = 1'b0; din1 = '0; din_valid1 = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wr_en", wr_en, '0);
    chk("rst_bits", bits, '0);
    chk("rst_din_ready", din_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_state", state_dbg, 3'd0);
    chk("rst_bits1", bits1, 16'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_din_ready", din_ready, 1'b0);

    // Load A: gapless, four tiles, latency measured start to done
`ifdef CFG_CHECK_EN
    lat_exp = NT * (10 + 2) + 2;
`else
    lat_exp = NT * (10 + 1) + 2;
`endif
    lat_on = 1'b1;
    do_start();
    send_frame(A0, A0_E, 0, 0, -1, 1'b0);
    send_frame(A1, A1_E, 1, 0, -1, 1'b0);
    send_frame(A2, A2_E, 2, 0, -1, 1'b0);
    send_frame(A3, A3_E, 3, 0, -1, 1'b0);
    wait_done();
    lat_on = 1'b0;
    chk("load_a_done_cnt", done_cnt, 1);
    chk("load_a_bits_hold", bits, A3_E);
    chk("load_a_wr_idle", wr_en, '0);
    chk("load_a_busy_low", busy, 1'b0);

    // Load B: din_valid every other cycle, stray start during tile 1
    do_start();
    send_frame(B0, B0_E, 0, 1, -1, 1'b0);
    send_frame(B1, B1_E, 1, 1, 3, 1'b0);
    send_frame(B2, B2_E, 2, 1, -1, 1'b0);
    send_frame(B3, B3_E, 3, 1, -1, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("load_b_done_cnt", done_cnt, 2);
    chk("load_b_no_restart", busy, 1'b0);
    chk("load_b_bits_hold", bits, B3_E);

    // Reset after word 5 of tile 2
    do_start();
    send_frame(A0, A0_E, 0, 0, -1, 1'b0);
    send_frame(A1, A1_E, 1, 0, -1, 1'b0);
    for (int i = 0; i < 5; i++) send_word(A2[79-8*i -: 8], 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", wr_en, '0);
    chk("mid_rst_bits", bits, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_din_ready", din_ready, 1'b0);
    chk("mid_rst_state", state_dbg, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_queue_drained", exp_q.size(), 0);
    chk("mid_rst_done_cnt", done_cnt, 2);

    // Reload from tile 0 after the abandoned sequence
    do_start();
    send_frame(C0, C0_E, 0, 0, -1, 1'b0);
    send_frame(A1, A1_E, 1, 0, -1, 1'b0);
    send_frame(A2, A2_E, 2, 0, -1, 1'b0);
    send_frame(B3, B3_E, 3, 0, -1, 1'b0);
    wait_done();
    chk("reload_done_cnt", done_cnt, 3);
    chk("reload_err", err, 1'b0);

`ifdef CFG_CHECK_EN
    // Bad check word on tile 1: tile 0 written, then error and done
    err_exp = 1'b1;
    do_start();
    send_frame(A0, A0_E, 0, 0, -1, 1'b0);
    send_frame(A1, A1_E, 1, 0, -1, 1'b1);
    wait_done();
    chk("chk_err_done_cnt", done_cnt, 4);
    chk("chk_err_sticky", err, 1'b1);
    chk("chk_err_bits_hold", bits, A0_E);
    err_exp = 1'b0;
    do_start();
    chk("chk_err_cleared", err, 1'b0);
    send_frame(B0, B0_E, 0, 0, -1, 1'b0);
    send_frame(B1, B1_E, 1, 0, -1, 1'b0);
    send_frame(B2, B2_E, 2, 0, -1, 1'b0);
    send_frame(B3, B3_E, 3, 0, -1, 1'b0);
    wait_done();
    chk("chk_recover_done_cnt", done_cnt, 5);
`endif

    // Single-tile instance: A5, 3C -> 16'hA53C
    exp1_q.push_back({1'b1, 16'hA53C});
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("one_busy", busy1, 1'b1);
    din1 = 8'hA5; din_valid1 = 1'b1;
    @(negedge clk);
    din1 = 8'h3C;
    @(negedge clk);
`ifdef CFG_CHECK_EN
    din1 = 8'h99;
    @(negedge clk);
`endif
    din_valid1 = 1'b0;
    g = 0;
    while (!done1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("one_done_seen", done1, 1'b1);
    chk("one_busy_low", busy1, 1'b0);
    chk("one_bits_hold", bits1, 16'hA53C);
    chk("one_err", err1, 1'b0);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_queue1_empty", exp1_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
